// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver (LSB first) with mid-bit sampling, stop-bit
//               check, sticky framing error and a fixed-length rx_done level.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DONE_HOLD    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4,
        S_BRK   = 3'd5
    } state_t;

    localparam logic [15:0] C_HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] C_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] C_HOLD = 16'(DONE_HOLD - 1);

    state_t      state_q,     state_d;
    logic        sync1_q,     sync1_d;
    logic        rx_s_q,      rx_s_d;
    logic [15:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  sh_q,        sh_d;
    logic [7:0]  rx_data_q,   rx_data_d;
    logic        rx_done_q,   rx_done_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q,      busy_d;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx;
        rx_s_d      = sync1_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        sh_d        = sh_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = rx_done_q;
        frame_err_d = frame_err_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    clk_cnt_d = 16'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == C_HALF) begin
                    clk_cnt_d = 16'd0;
                    if (!rx_s_q) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == C_FULL) begin
                    clk_cnt_d         = 16'd0;
                    sh_d[bit_idx_q]   = rx_s_q;
                    bit_idx_d         = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == C_FULL) begin
                    clk_cnt_d = 16'd0;
                    if (rx_s_q) begin
                        rx_data_d   = sh_q;
                        rx_done_d   = 1'b1;
                        frame_err_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BRK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                // Short enough to return to IDLE before the next start edge can arrive.
                if (clk_cnt_q == C_HOLD) begin
                    clk_cnt_d = 16'd0;
                    rx_done_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_BRK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            clk_cnt_q   <= 16'd0;
            bit_idx_q   <= 3'd0;
            sh_q        <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            sh_q        <= sh_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Scoreboard bench for uart_rx_byte with a simple IO-loader model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int CPB     = 16;
    localparam int HOLD    = 4;
    localparam int LAT_MIN = 2 + (CPB - 1) / 2 + 9 * CPB;
    localparam int LAT_MAX = LAT_MIN + 3;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [7:0] last_good;

    // IO loader: latch on rx_done high, re-arm on rx_done low
    logic [7:0] ram [0:3];
    logic [2:0] ld_addr;
    logic       ld_armed;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .DONE_HOLD    (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            ld_addr  <= 3'd0;
            ld_armed <= 1'b1;
        end else if (rx_done && ld_armed) begin
            if (ld_addr < 3'd4) ram[ld_addr[1:0]] <= rx_data;
            ld_addr  <= ld_addr + 3'd1;
            ld_armed <= 1'b0;
        end else if (!rx_done) begin
            ld_armed <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        wait_cycles(n);
    endtask

    // Frame on the wire: start(0), 8 data bits LSB first, stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        if (stop) begin
            e.data  = d;
            e.start = cyc;
            exp_q.push_back(e);
        end
        drive_bit(1'b0, CPB);
        for (int k = 0; k < 8; k++) drive_bit(d[k], CPB);
        drive_bit(stop, CPB);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        rx    = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each rx_done rise
    initial begin : monitor
        logic       prev_done;
        int         hold_len;
        logic [7:0] cap;
        logic       stable;
        exp_t       e;
        prev_done = 1'b0;
        hold_len  = 0;
        cap       = 8'd0;
        stable    = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_done && !prev_done) begin
                hold_len = 1;
                cap      = rx_data;
                stable   = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rx_done: got data %0h expected no pulse", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", rx_data, e.data);
                    chk("latency_in_window", (cyc - e.start >= LAT_MIN && cyc - e.start <= LAT_MAX), 1);
                    chk("frame_err_on_good", frame_err, 0);
                end
            end else if (rx_done) begin
                hold_len++;
                if (rx_data !== cap) stable = 1'b0;
            end else if (prev_done) begin
                chk("rx_done_len", hold_len, HOLD);
                chk("rx_data_stable", stable, 1);
            end
            prev_done = rx_done;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b;
        logic       bad;
        int         w;
        cyc       = 0;
        n_checks  = 0;
        n_fail    = 0;
        last_good = 8'd0;
        rx        = 1'b1;
        reset     = 1'b1;
        wait_cycles(3);
        reset = 1'b0;

        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        wait_cycles(5);

        // 1: single good byte
        send_frame(8'hA5, 1'b1);
        last_good = 8'hA5;
        wait_cycles(10);
        chk("t1_frame_err", frame_err, 0);

        // 2: short glitch
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        chk("t2_busy_during_glitch", busy, 1);
        wait_cycles(10);
        chk("t2_busy_dropped", busy, 0);
        chk("t2_rx_data_kept", rx_data, last_good);

        // 3: bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0);
        wait_cycles(40);
        chk("t3_frame_err_set", frame_err, 1);
        chk("t3_rx_data_kept", rx_data, 8'hA5);
        chk("t3_busy_in_brk", busy, 1);
        rx = 1'b1;
        wait_cycles(6);
        chk("t3_busy_after_brk", busy, 0);
        send_frame(8'h01, 1'b1);
        last_good = 8'h01;
        wait_cycles(4);
        chk("t3_frame_err_cleared", frame_err, 0);
        wait_cycles(10);

        // 4: back-to-back frames
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        last_good = 8'h55;
        wait_cycles(10);

        // 5: reset in data bit 4 of 0x99
        b = 8'h99;
        drive_bit(1'b0, CPB);
        for (int k = 0; k < 4; k++) drive_bit(b[k], CPB);
        drive_bit(b[4], CPB / 2);
        pulse_reset();
        chk("t5_rx_data", rx_data, 0);
        chk("t5_rx_done", rx_done, 0);
        chk("t5_frame_err", frame_err, 0);
        chk("t5_busy", busy, 0);
        last_good = 8'h00;
        wait_cycles(5);
        send_frame(8'h7E, 1'b1);
        last_good = 8'h7E;
        wait_cycles(10);

        // Randomized frames, some with a bad stop bit
        for (int i = 0; i < 14; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(b, !bad);
            wait_cycles(2);
            chk("rand_frame_err", frame_err, bad);
            if (bad) begin
                chk("rand_rx_data_kept", rx_data, last_good);
                w = $urandom_range(10, 40);
                wait_cycles(w);
            end else begin
                last_good = b;
            end
            rx = 1'b1;
            w  = $urandom_range(3, 20);
            wait_cycles(w);
        end

        // 6: loader streaming
        pulse_reset();
        wait_cycles(5);
        for (int i = 1; i <= 4; i++) send_frame(8'(i * 8'h11), 1'b1);
        wait_cycles(20);
        for (int i = 0; i < 4; i++) chk("t6_ram", ram[i], 32'((i + 1) * 8'h11));
        chk("t6_addr", ld_addr, 4);

        begin : drain
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 400) begin
                wait_cycles(1);
                t++;
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end
        wait_cycles(HOLD + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
